// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 operation codes, sequencer states and decode helpers.
package riscv_m_pkg;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } m_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

    function automatic logic is_div_op(input m_op_e op);
        return op[2];
    endfunction

    function automatic logic signed_a(input m_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic signed_b(input m_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide step.
module muldiv_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     opnd,
    output logic [2*DATA_W-1:0]   acc_next
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] trial;
    logic [DATA_W:0] diff;

    always_comb begin
        sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: acc holds {remainder, quotient}; shift in the next dividend bit.
        trial = acc[2*DATA_W-1:DATA_W-1];
        diff  = trial - {1'b0, opnd};
        if (is_div) begin
            if (!diff[DATA_W]) begin
                acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            end else begin
                acc_next = {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle, stalls the pipeline until done.
module muldiv_sequencer
    import riscv_m_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] srcA,
    input  logic [DATA_W-1:0] srcB,
    input  logic              flush,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    md_state_e           state;
    m_op_e               op;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [DATA_W-1:0]   opnd;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_step;
    logic [CNT_W-1:0]    counter;
    logic                neg_a;
    logic                neg_b;

    logic                sa;
    logic                sb;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic                div_op;
    logic                div_zero;
    logic                div_ovf;
    logic [DATA_W-1:0]   fast_val;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   fix_val;

    muldiv_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .is_div   (div_op),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_step)
    );

    // Operand preparation on the latched operands (used in PREP).
    always_comb begin
        div_op   = is_div_op(op);
        sa       = signed_a(op) & a_reg[DATA_W-1];
        sb       = signed_b(op) & b_reg[DATA_W-1];
        mag_a    = sa ? ('0 - a_reg) : a_reg;
        mag_b    = sb ? ('0 - b_reg) : b_reg;
        div_zero = div_op && (b_reg == '0);
        div_ovf  = ((op == DIV) || (op == REM)) && (a_reg == {1'b1, {(DATA_W-1){1'b0}}})
                   && (b_reg == '1);
        if (div_zero) begin
            fast_val = ((op == DIV) || (op == DIVU)) ? '1 : a_reg;
        end else begin
            fast_val = (op == DIV) ? a_reg : '0;
        end
    end

    // Sign correction and field selection (used in FIX).
    always_comb begin
        prod = (neg_a ^ neg_b) ? ('0 - acc) : acc;
        quo  = acc[DATA_W-1:0];
        rem  = acc[2*DATA_W-1:DATA_W];
        case (op)
            MUL:                fix_val = prod[DATA_W-1:0];
            MULH, MULHSU, MULHU: fix_val = prod[2*DATA_W-1:DATA_W];
            DIV, DIVU:          fix_val = (neg_a ^ neg_b) ? ('0 - quo) : quo;
            default:            fix_val = neg_a ? ('0 - rem) : rem;
        endcase
    end

    assign stall = (start && (state == IDLE) && !flush) ||
                   (state == PREP) || (state == CALC) || (state == FIX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op      <= MUL;
            a_reg   <= '0;
            b_reg   <= '0;
            opnd    <= '0;
            acc     <= '0;
            counter <= '0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Squash: a DONE already in flight has pulsed done this cycle.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            op    <= m_op_e'(funct3);
                            a_reg <= srcA;
                            b_reg <= srcB;
                            state <= PREP;
                            busy  <= 1'b1;
                        end
                    end
                    PREP: begin
                        neg_a   <= sa;
                        neg_b   <= sb;
                        counter <= CNT_W'(DATA_W - 1);
                        if (div_zero || div_ovf) begin
                            result <= fast_val;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            acc   <= div_op ? {{DATA_W{1'b0}}, mag_a} : {{DATA_W{1'b0}}, mag_b};
                            opnd  <= div_op ? mag_b : mag_a;
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        acc <= acc_step;
                        if (counter == '0) begin
                            state <= FIX;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    FIX: begin
                        result <= fix_val;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a 64-bit arithmetic reference.
module tb_muldiv_sequencer;

    localparam int DATA_W = 32;
    localparam int LAT    = DATA_W + 3;

    logic              clk;
    logic              reset;
    logic              start;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] srcA;
    logic [DATA_W-1:0] srcB;
    logic              flush;
    logic              busy;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] result;

    int unsigned       n_checks;
    int unsigned       n_errors;
    logic [31:0]       last_result;

    muldiv_sequencer #(
        .DATA_W (DATA_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .srcA   (srcA),
        .srcB   (srcB),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed with wide signed/unsigned arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && b == 0) return 2;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return LAT;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic stall_ok;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        srcA   = a;
        srcB   = b;
        #1 stall_ok = stall;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (!done) stall_ok = stall_ok & stall;
        end while (!done && lat < 100);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_stall"}, 64'(stall_ok), 64'd1);
        check({tag, "_stall_in_done"}, 64'(stall), 64'd0);
        last_result = exp_res;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int   lat;
        int   seen_done;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        n_checks    = 0;
        n_errors    = 0;
        last_result = '0;
        reset  = 1'b0;
        start  = 1'b0;
        funct3 = '0;
        srcA   = '0;
        srcB   = '0;
        flush  = 1'b0;

        vecs[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT};
        vecs[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, LAT};
        vecs[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, LAT};
        vecs[8]  = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2};
        vecs[9]  = '{3'd6, 32'd5, 32'd0, 32'd5, 2};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2};

        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("dir%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r,
                   vecs[i].lat);
        end

        for (int i = 0; i < 30; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = rand_operand();
            rb = rand_operand();
            run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, ref_model(rf, ra, rb),
                   ref_latency(rf, ra, rb));
        end

        // Flush during CALC: cycle 10 after start.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; srcA = 32'd1234; srcB = 32'd5678;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_result", 64'(result), 64'(last_result));
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("flush_no_done", 64'(seen_done), 64'd0);

        // Start and flush in the same cycle.
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; srcA = 32'd9; srcB = 32'd3;
        #1 check("startflush_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("startflush_busy", 64'(busy), 64'd0);

        // Start held high while busy; operands change but must be ignored.
        start = 1'b1; funct3 = 3'd3; srcA = 32'hDEAD_BEEF; srcB = 32'h1234_5678;
        @(negedge clk);
        funct3 = 3'd5; srcA = 32'd1000; srcB = 32'd33;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("held_lat", 64'(lat), 64'(LAT));
        check("held_res", 64'(result), 64'(ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678)));
        // Start still high: accepted in the cycle after DONE.
        @(negedge clk);
        check("held_done_pulse", 64'(done), 64'd0);
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 100);
        check("b2b_lat", 64'(lat), 64'(LAT));
        check("b2b_res", 64'(result), 64'(ref_model(3'd5, 32'd1000, 32'd33)));

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd1; srcA = 32'h1234_5678; srcB = 32'h9ABC_DEF0;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        last_result = '0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("arst_no_done", 64'(seen_done), 64'd0);
        run_op("post_reset", 3'd6, 32'hFFFF_FF9C, 32'd7, ref_model(3'd6, 32'hFFFF_FF9C, 32'd7),
               LAT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
